// File: rtl/intl_fault_latch.sv
// Interlock fault collector: debounces raw detector flags, latches qualified faults with a
// first-fault record and timestamp, and sequences a clear pulse back to the detectors.
module intl_fault_latch #(
  parameter int unsigned N_SRC  = 8,
  parameter int unsigned DBNC_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_SRC-1:0]  i_flag,
  input  logic [N_SRC-1:0]  i_mask,
  input  logic [DBNC_W-1:0] i_debounce,
  input  logic              i_clr,
  output logic              o_src_clr,
  output logic              o_intl,
  output logic [N_SRC-1:0]  o_fault_latch,
  output logic [N_SRC-1:0]  o_first_fault,
  output logic [31:0]       o_first_ts,
  output logic [15:0]       o_event_cnt,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFault  = 2'd1,
    StClear  = 2'd2,
    StSettle = 2'd3
  } state_e;

  localparam logic [DBNC_W-1:0] CntOne = DBNC_W'(1);

  state_e            state_q;
  logic              settle_q;
  logic [31:0]       ts_q;
  logic [DBNC_W-1:0] cnt_q [N_SRC];
  logic [DBNC_W-1:0] cnt_d [N_SRC];
  logic [N_SRC-1:0]  act;
  logic [N_SRC-1:0]  qual;
  logic [N_SRC-1:0]  latch_q;
  logic [N_SRC-1:0]  first_q;
  logic [31:0]       first_ts_q;
  logic [15:0]       event_cnt_q;
  logic              src_clr_q;
  logic              intl_q;

  assign act = i_flag & ~i_mask;

  // Counters are forced to zero during SETTLE so detector clear latency cannot re-qualify.
  always_comb begin
    for (int unsigned i = 0; i < N_SRC; i++) begin
      qual[i] = act[i] & (cnt_q[i] >= i_debounce);
      if ((state_q == StSettle) || !act[i]) begin
        cnt_d[i] = '0;
      end else if (&cnt_q[i]) begin
        cnt_d[i] = cnt_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CntOne;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= StIdle;
      settle_q    <= 1'b0;
      ts_q        <= '0;
      latch_q     <= '0;
      first_q     <= '0;
      first_ts_q  <= '0;
      event_cnt_q <= '0;
      src_clr_q   <= 1'b0;
      intl_q      <= 1'b0;
    end else begin
      ts_q      <= ts_q + 32'd1;
      src_clr_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|qual) begin
            state_q    <= StFault;
            latch_q    <= qual;
            first_q    <= qual;
            first_ts_q <= ts_q;
            intl_q     <= 1'b1;
            if (event_cnt_q != 16'hFFFF) begin
              event_cnt_q <= event_cnt_q + 16'd1;
            end
          end
        end
        StFault: begin
          // A clear request takes priority over any fault qualifying in the same cycle.
          if (i_clr) begin
            state_q   <= StClear;
            src_clr_q <= 1'b1;
          end else begin
            latch_q <= latch_q | qual;
          end
        end
        StClear: begin
          state_q    <= StSettle;
          settle_q   <= 1'b0;
          latch_q    <= '0;
          first_q    <= '0;
          first_ts_q <= '0;
          intl_q     <= 1'b0;
        end
        StSettle: begin
          settle_q <= 1'b1;
          if (settle_q) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_src_clr     = src_clr_q;
  assign o_intl        = intl_q;
  assign o_fault_latch = latch_q;
  assign o_first_fault = first_q;
  assign o_first_ts    = first_ts_q;
  assign o_event_cnt   = event_cnt_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_intl_fault_latch.sv
// Bench for intl_fault_latch: a cycle-level reference model feeds an expectation queue that
// an independent monitor drains on every falling edge; directed scenarios then random traffic.
module tb_intl_fault_latch;

  localparam int N = 8;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [7:0]  i_flag = '0;
  logic [7:0]  i_mask = '0;
  logic [15:0] i_debounce = '0;
  logic        i_clr = 1'b0;
  logic        o_src_clr;
  logic        o_intl;
  logic [7:0]  o_fault_latch;
  logic [7:0]  o_first_fault;
  logic [31:0] o_first_ts;
  logic [15:0] o_event_cnt;
  logic [1:0]  o_state;

  intl_fault_latch #(.N_SRC(8), .DBNC_W(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flag(i_flag), .i_mask(i_mask),
    .i_debounce(i_debounce), .i_clr(i_clr), .o_src_clr(o_src_clr), .o_intl(o_intl),
    .o_fault_latch(o_fault_latch), .o_first_fault(o_first_fault), .o_first_ts(o_first_ts),
    .o_event_cnt(o_event_cnt), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        src_clr;
    logic        intl;
    logic [7:0]  latch;
    logic [7:0]  first;
    logic [31:0] ts;
    logic [15:0] ev;
    logic [1:0]  st;
  } snap_t;

  snap_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: run[i] = how many consecutive prior cycles source i was active.
  int          run [N];
  int          mst;          // 0 idle, 1 fault, 2 clear, 3 settle
  int          settle_left;
  int unsigned mts;
  bit [7:0]    mlatch;
  bit [7:0]    mfirst;
  int unsigned mfts;
  int          mev;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) run[i] = 0;
    mst = 0; settle_left = 0; mts = 0; mlatch = '0; mfirst = '0; mfts = 0; mev = 0;
  endfunction

  function automatic void model_step();
    bit [7:0] act;
    bit [7:0] q;
    act = i_flag & ~i_mask;
    for (int i = 0; i < N; i++) q[i] = act[i] && (run[i] >= int'(i_debounce));
    for (int i = 0; i < N; i++) run[i] = (mst == 3 || !act[i]) ? 0 : run[i] + 1;
    case (mst)
      0: if (q != 0) begin
           mst = 1; mlatch = q; mfirst = q; mfts = mts;
           if (mev < 65535) mev = mev + 1;
         end
      1: if (i_clr) mst = 2; else mlatch = mlatch | q;
      2: begin mst = 3; mlatch = '0; mfirst = '0; mfts = 0; settle_left = 2; end
      default: begin settle_left = settle_left - 1; if (settle_left == 0) mst = 0; end
    endcase
    mts = mts + 1;
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.src_clr = (mst == 2);
    s.intl    = (mlatch != 0);
    s.latch   = mlatch;
    s.first   = mfirst;
    s.ts      = mfts;
    s.ev      = 16'(mev);
    s.st      = 2'(mst);
    return s;
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.src_clr = o_src_clr; s.intl = o_intl; s.latch = o_fault_latch; s.first = o_first_fault;
    s.ts = o_first_ts; s.ev = o_event_cnt; s.st = o_state;
    return s;
  endfunction

  // Monitor: one expected snapshot per clock, compared away from the active edge.
  initial begin
    snap_t e;
    snap_t a;
    forever begin
      @(negedge i_clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = dut_snap();
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          if (n_bad <= 20)
            $display("FAIL snapshot t=%0t got clr=%0b intl=%0b latch=%h first=%h ts=%0d ev=%0d st=%0d want clr=%0b intl=%0b latch=%h first=%h ts=%0d ev=%0d st=%0d",
                     $time, a.src_clr, a.intl, a.latch, a.first, a.ts, a.ev, a.st,
                     e.src_clr, e.intl, e.latch, e.first, e.ts, e.ev, e.st);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    if (i_rst) begin
      model_step();
      cyc++;
    end else begin
      model_reset();
      cyc = 0;
    end
    exp_q.push_back(model_snap());
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse_clr();
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
  endtask

  // Reset dropped between edges: outputs must clear without waiting for a clock.
  task automatic async_reset(input bit check_now);
    i_rst = 1'b0;
    #1;
    if (check_now) begin
      chk("async_rst_outputs", {o_src_clr, o_intl, o_fault_latch, o_first_fault, o_state}, 0);
      chk("async_rst_ts_ev", {o_first_ts[15:0], o_event_cnt}, 0);
    end
    exp_q.delete();
    model_reset();
    cyc = 0;
    exp_q.push_back(model_snap());
    ticks(2);
    i_rst = 1'b1;
  endtask

  int k0;

  initial begin
    model_reset();
    ticks(3);
    chk("reset_outputs", {o_src_clr, o_intl, o_fault_latch, o_first_fault, o_state}, 0);
    chk("reset_event_cnt", {16'h0, o_event_cnt}, 0);
    i_rst = 1'b1;
    ticks(2);

    // Glitch of exactly D cycles never latches.
    i_debounce = 16'd3;
    i_flag = 8'h04;
    ticks(3);
    i_flag = 8'h00;
    ticks(5);
    chk("glitch_intl", {31'h0, o_intl}, 0);
    chk("glitch_latch", {24'h0, o_fault_latch}, 0);

    // Sustained flag qualifies at t+D, latches at t+D+1.
    k0 = cyc;
    i_flag = 8'h04;
    ticks(3);
    chk("dbnc_not_yet", {24'h0, o_fault_latch}, 0);
    tick();
    chk("dbnc_latch", {24'h0, o_fault_latch}, 32'h04);
    chk("dbnc_intl", {31'h0, o_intl}, 1);
    chk("dbnc_first_ts", o_first_ts, 32'(k0 + 3));
    chk("dbnc_event_cnt", {16'h0, o_event_cnt}, 1);

    // Clear sequence with flags low.
    i_flag = 8'h00;
    pulse_clr();
    chk("clr_state2", {30'h0, o_state}, 2);
    chk("clr_pulse", {31'h0, o_src_clr}, 1);
    tick();
    chk("settle1_state", {30'h0, o_state}, 3);
    chk("settle1_latch", {o_fault_latch, o_first_fault, 15'h0, o_intl}, 0);
    chk("settle1_no_pulse", {31'h0, o_src_clr}, 0);
    tick();
    chk("settle2_state", {30'h0, o_state}, 3);
    tick();
    chk("back_idle", {30'h0, o_state}, 0);

    // Simultaneous first faults, later addition does not move first-fault.
    i_debounce = 16'd0;
    i_flag = 8'h22;
    tick();
    chk("multi_first", {24'h0, o_first_fault}, 32'h22);
    i_flag = 8'h23;
    tick();
    chk("multi_latch", {24'h0, o_fault_latch}, 32'h23);
    chk("multi_first_kept", {24'h0, o_first_fault}, 32'h22);
    i_flag = 8'h00;
    pulse_clr();
    ticks(3);

    // Clear while the source stays high re-latches after settle.
    i_flag = 8'h10;
    tick();
    chk("persist_ev3", {16'h0, o_event_cnt}, 3);
    pulse_clr();
    ticks(3);
    chk("persist_idle", {30'h0, o_state}, 0);
    tick();
    chk("persist_relatch", {24'h0, o_fault_latch}, 32'h10);
    chk("persist_ev4", {16'h0, o_event_cnt}, 4);
    i_flag = 8'h00;
    pulse_clr();
    ticks(3);

    // i_clr in IDLE is ignored.
    pulse_clr();
    chk("idle_clr_ignored", {29'h0, o_src_clr, o_state}, 0);

    // Masked source never latches; then reset in FAULT.
    i_mask = 8'h08;
    i_flag = 8'h08;
    ticks(100);
    chk("masked_no_latch", {24'h0, o_fault_latch}, 0);
    i_mask = 8'h00;
    ticks(2);
    chk("unmasked_fault", {30'h0, o_state}, 1);
    async_reset(1'b1);
    i_flag = 8'h00;
    ticks(2);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) i_debounce = 16'($urandom_range(0, 5));
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 9) == 0) i_flag[b] = ~i_flag[b];
      if ($urandom_range(0, 99) == 0) i_mask = 8'($urandom) & 8'($urandom);
      i_clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 999) == 0) begin
        i_clr = 1'b0;
        async_reset(1'b0);
      end else begin
        tick();
      end
    end
    i_clr = 1'b0;
    tick();
    @(negedge i_clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
